// File: rtl/mpu_pkg.sv
// mpu_pkg: constants and helpers shared by the MPU ALU sequencer, its
// register file and the verification model.
//   - ALU opcode encodings (NONE/MASK/CMP/LT)
//   - ALU lane-size encodings (B/W/DW/QW)
//   - sequencer FSM state encoding
//   - lane_offset / lane_mask: where a result lane sits inside a 64-bit word
package mpu_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_MASK = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_LT   = 4'd3;

    localparam logic [1:0] SZ_B  = 2'd0;
    localparam logic [1:0] SZ_W  = 2'd1;
    localparam logic [1:0] SZ_DW = 2'd2;
    localparam logic [1:0] SZ_QW = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } mpu_state_t;

    // Lane bit offset: (sel * (8 << size)) mod 64. The product fits in 9 bits;
    // keeping only the low 6 bits gives the wrap the ALU lane shifter uses.
    function automatic logic [5:0] lane_offset(input logic [1:0] size,
                                               input logic [2:0] sel);
        logic [8:0] prod;
        prod = {6'd0, sel} << (3'd3 + {1'b0, size});
        return prod[5:0];
    endfunction

    // Lane mask: all-ones for 64-bit lanes, else the lane-width ones field
    // shifted to the lane offset (bits shifted past bit 63 are dropped).
    function automatic logic [63:0] lane_mask(input logic [1:0] size,
                                              input logic [2:0] sel);
        logic [63:0] ones;
        case (size)
            SZ_B:    ones = 64'h0000_0000_0000_00FF;
            SZ_W:    ones = 64'h0000_0000_0000_FFFF;
            SZ_DW:   ones = 64'h0000_0000_FFFF_FFFF;
            default: ones = '1;
        endcase
        return ones << lane_offset(size, sel);
    endfunction

endpackage

// File: rtl/mpu_regfile.sv
// mpu_regfile: NREGS x 64-bit operand register file.
//   sys_clk, sys_rst_n     clock, async active-low reset (clears every entry)
//   rd_en, ra/rb/rc        synchronous operand read; q0/q1/q2 hold until next rd_en
//   host_raddr/host_rdata  combinational host read port
//   host_we/waddr/wdata    host write port
//   wb_we/waddr/mask/wdata masked writeback port; beats the host port on the
//                          same entry in the same cycle
module mpu_regfile #(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic [AW-1:0] rc,
    output logic [63:0]   q0,
    output logic [63:0]   q1,
    output logic [63:0]   q2,
    input  logic [AW-1:0] host_raddr,
    output logic [63:0]   host_rdata,
    input  logic          host_we,
    input  logic [AW-1:0] host_waddr,
    input  logic [63:0]   host_wdata,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_waddr,
    input  logic [63:0]   wb_mask,
    input  logic [63:0]   wb_wdata
);

    logic [NREGS-1:0][63:0] mem;

    assign host_rdata = mem[host_raddr];

    // Masked merge reads the pre-edge entry, so a host write landing in an
    // earlier cycle survives outside the mask.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_we && wb_waddr == AW'(i))
                    mem[i] <= (mem[i] & ~wb_mask) | (wb_wdata & wb_mask);
                else if (host_we && host_waddr == AW'(i))
                    mem[i] <= host_wdata;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            q0 <= '0;
            q1 <= '0;
            q2 <= '0;
        end else if (rd_en) begin
            q0 <= mem[ra];
            q1 <= mem[rb];
            q2 <= mem[rc];
        end
    end

endmodule

// File: rtl/mpu_alu_seq.sv
// mpu_alu_seq: sequences one ALU instruction through IDLE -> FETCH -> EXEC -> WB.
//   i_valid/i_ready + i_*  instruction handshake and fields (latched on accept)
//   alu_*                  registered drive to the external ALU; alu_res returns
//   wr_en/wr_addr/wr_data  host register load port (any state)
//   rd_addr/rd_data        combinational host read port
//   done/done_bit          one-cycle pulse during WB with the lane's boolean result
//   busy                   high whenever the FSM is not IDLE
module mpu_alu_seq
    import mpu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [3:0]    i_op,
    input  logic [1:0]    i_size,
    input  logic [AW-1:0] i_ra,
    input  logic [AW-1:0] i_rb,
    input  logic [AW-1:0] i_rc,
    input  logic [AW-1:0] i_rd,
    input  logic [2:0]    i_s0,
    input  logic [2:0]    i_s1,
    input  logic [2:0]    i_s2,
    input  logic [2:0]    i_sres,
    output logic [3:0]    alu_op,
    output logic [1:0]    alu_size,
    output logic [63:0]   alu_o0,
    output logic [63:0]   alu_o1,
    output logic [63:0]   alu_o2,
    output logic [2:0]    alu_s0,
    output logic [2:0]    alu_s1,
    output logic [2:0]    alu_s2,
    output logic [2:0]    alu_sres,
    input  logic [63:0]   alu_res,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data,
    output logic          done,
    output logic          done_bit,
    output logic          busy
);

    mpu_state_t    state;
    logic [3:0]    op_q;
    logic [1:0]    size_q;
    logic [AW-1:0] ra_q, rb_q, rc_q, rd_q;
    logic [2:0]    s0_q, s1_q, s2_q, sres_q;
    logic [63:0]   result_q;

    assign i_ready  = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign alu_op   = op_q;
    assign alu_size = size_q;
    assign alu_s0   = s0_q;
    assign alu_s1   = s1_q;
    assign alu_s2   = s2_q;
    assign alu_sres = sres_q;

    // Operand registers live in the regfile's sync read ports; they load only
    // in FETCH so alu_o* stay put through EXEC.
    mpu_regfile #(.NREGS(NREGS), .AW(AW)) u_rf (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rd_en      (state == ST_FETCH),
        .ra         (ra_q),
        .rb         (rb_q),
        .rc         (rc_q),
        .q0         (alu_o0),
        .q1         (alu_o1),
        .q2         (alu_o2),
        .host_raddr (rd_addr),
        .host_rdata (rd_data),
        .host_we    (wr_en),
        .host_waddr (wr_addr),
        .host_wdata (wr_data),
        .wb_we      (state == ST_WB),
        .wb_waddr   (rd_q),
        .wb_mask    (lane_mask(size_q, sres_q)),
        .wb_wdata   (result_q)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            size_q   <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            rd_q     <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            sres_q   <= '0;
            result_q <= '0;
            done     <= 1'b0;
            done_bit <= 1'b0;
        end else begin
            done     <= 1'b0;
            done_bit <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        op_q   <= i_op;
                        size_q <= i_size;
                        ra_q   <= i_ra;
                        rb_q   <= i_rb;
                        rc_q   <= i_rc;
                        rd_q   <= i_rd;
                        s0_q   <= i_s0;
                        s1_q   <= i_s1;
                        s2_q   <= i_s2;
                        sres_q <= i_sres;
                        state  <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    // done/done_bit are set here so they are visible for the
                    // whole WB cycle in which the regfile commits the result.
                    result_q <= alu_res;
                    done     <= 1'b1;
                    done_bit <= alu_res[lane_offset(size_q, sres_q)];
                    state    <= ST_WB;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_alu_seq.sv
module tb_mpu_alu_seq;
    import mpu_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        i_valid, i_ready;
    logic [3:0]  i_op;
    logic [1:0]  i_size;
    logic [2:0]  i_ra, i_rb, i_rc, i_rd;
    logic [2:0]  i_s0, i_s1, i_s2, i_sres;
    logic [3:0]  alu_op;
    logic [1:0]  alu_size;
    logic [63:0] alu_o0, alu_o1, alu_o2;
    logic [2:0]  alu_s0, alu_s1, alu_s2, alu_sres;
    logic [63:0] alu_res;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [63:0] wr_data;
    logic [2:0]  rd_addr;
    logic [63:0] rd_data;
    logic        done, done_bit, busy;

    int checks = 0;
    int passes = 0;

    always #5 sys_clk = ~sys_clk;

    mpu_alu_seq #(.NREGS(8), .AW(3)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op), .i_size(i_size),
        .i_ra(i_ra), .i_rb(i_rb), .i_rc(i_rc), .i_rd(i_rd),
        .i_s0(i_s0), .i_s1(i_s1), .i_s2(i_s2), .i_sres(i_sres),
        .alu_op(alu_op), .alu_size(alu_size),
        .alu_o0(alu_o0), .alu_o1(alu_o1), .alu_o2(alu_o2),
        .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_sres(alu_sres),
        .alu_res(alu_res),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .done(done), .done_bit(done_bit), .busy(busy)
    );

    // ALU model: boolean of the selected lanes, placed at the result lane.
    logic [63:0] lw, la, lb, lc;
    logic        lbool;
    always_comb begin
        lw = '1;
        case (alu_size)
            2'd0: lw = 64'hFF;
            2'd1: lw = 64'hFFFF;
            2'd2: lw = 64'hFFFF_FFFF;
            default: lw = '1;
        endcase
        la = (alu_o0 >> lane_offset(alu_size, alu_s0)) & lw;
        lb = (alu_o1 >> lane_offset(alu_size, alu_s1)) & lw;
        lc = (alu_o2 >> lane_offset(alu_size, alu_s2)) & lw;
        lbool = 1'b0;
        case (alu_op)
            OP_MASK: lbool = (la & lc) != 64'd0;
            OP_CMP:  lbool = (la == lb);
            OP_LT:   lbool = (la < lb);
            default: lbool = 1'b0;
        endcase
        alu_res = lbool ? (64'd1 << lane_offset(alu_size, alu_sres)) : 64'd0;
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic load_reg(input logic [2:0] a, input logic [63:0] d);
        wr_addr = a; wr_data = d; wr_en = 1'b1;
        @(posedge sys_clk); #1;
        wr_en = 1'b0;
    endtask

    // Issues one instruction from IDLE and watches 6 cycles after accept.
    // hw_k: cycle after accept (1=FETCH, 2=EXEC, 3=WB) to drive a host write.
    task automatic run_instr(input logic [3:0] op, input logic [1:0] sz,
                             input logic [2:0] ra, input logic [2:0] rb,
                             input logic [2:0] rc, input logic [2:0] rd,
                             input logic [2:0] sres, input int hw_k,
                             input logic [2:0] hw_a, input logic [63:0] hw_d,
                             output int done_cyc, output int ndone,
                             output logic dbit, output logic [63:0] ex_o0,
                             output logic [3:0] ex_op, output int rdy_busy);
        done_cyc = -1; ndone = 0; dbit = 1'b0; ex_o0 = '0; ex_op = '0; rdy_busy = 0;
        i_op = op; i_size = sz; i_ra = ra; i_rb = rb; i_rc = rc; i_rd = rd;
        i_s0 = 3'd0; i_s1 = 3'd0; i_s2 = 3'd0; i_sres = sres;
        i_valid = 1'b1;
        @(posedge sys_clk); #1;
        i_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            wr_en = (k == hw_k);
            wr_addr = hw_a; wr_data = hw_d;
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin done_cyc = k; dbit = done_bit; end
            end
            if (k <= 3 && i_ready) rdy_busy++;
            if (k == 2) begin ex_o0 = alu_o0; ex_op = alu_op; end
            @(posedge sys_clk); #1;
        end
        wr_en = 1'b0;
    endtask

    int dc, nd, rb_cnt;
    logic db;
    logic [63:0] eo0;
    logic [3:0] eop;

    task automatic test_reset();
        checks++; if (i_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", i_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
        checks++; if ({done, done_bit} !== 2'b00) $display("FAIL reset_done got %b exp 00", {done, done_bit}); else passes++;
        checks++; if ({alu_o0, alu_op} !== 68'd0) $display("FAIL reset_alu got %h exp 0", {alu_o0, alu_op}); else passes++;
        rd_addr = 3'd4; #1;
        checks++; if (rd_data !== 64'd0) $display("FAIL reset_reg got %h exp 0", rd_data); else passes++;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_cmp();
        load_reg(3'd1, 64'h00FF);
        load_reg(3'd2, 64'h00FF);
        load_reg(3'd3, 64'hFFFF);
        load_reg(3'd4, 64'hAAAA_AAAA_AAAA_AAAA);
        run_instr(OP_CMP, 2'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 0, 3'd0, 64'd0, dc, nd, db, eo0, eop, rb_cnt);
        checks++; if (dc !== 3) $display("FAIL cmp_latency got %0d exp 3", dc); else passes++;
        checks++; if (nd !== 1) $display("FAIL cmp_ndone got %0d exp 1", nd); else passes++;
        checks++; if (db !== 1'b1) $display("FAIL cmp_done_bit got %b exp 1", db); else passes++;
        checks++; if (eo0 !== 64'h00FF || eop !== OP_CMP) $display("FAIL cmp_exec_alu got %h/%h exp ff/2", eo0, eop); else passes++;
        checks++; if (rb_cnt !== 0) $display("FAIL cmp_ready_busy got %0d exp 0", rb_cnt); else passes++;
        rd_addr = 3'd4; #1;
        checks++; if (rd_data !== 64'hAAAA_AAAA_AA01_AAAA) $display("FAIL cmp_r4 got %h exp aaaaaaaaaa01aaaa", rd_data); else passes++;
    endtask

    task automatic test_lt();
        load_reg(3'd1, 64'd5);
        load_reg(3'd2, 64'd7);
        load_reg(3'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        run_instr(OP_LT, 2'd3, 3'd1, 3'd2, 3'd0, 3'd5, 3'd0, 0, 3'd0, 64'd0, dc, nd, db, eo0, eop, rb_cnt);
        rd_addr = 3'd5; #1;
        checks++; if (rd_data !== 64'd1 || db !== 1'b1) $display("FAIL lt_true got %h/%b exp 1/1", rd_data, db); else passes++;
        load_reg(3'd1, 64'd7);
        load_reg(3'd2, 64'd5);
        run_instr(OP_LT, 2'd3, 3'd1, 3'd2, 3'd0, 3'd5, 3'd0, 0, 3'd0, 64'd0, dc, nd, db, eo0, eop, rb_cnt);
        rd_addr = 3'd5; #1;
        checks++; if (rd_data !== 64'd0 || db !== 1'b0) $display("FAIL lt_false got %h/%b exp 0/0", rd_data, db); else passes++;
        // rd aliasing ra: operands come from FETCH, r1 = (3 < 9)
        load_reg(3'd1, 64'd3);
        load_reg(3'd2, 64'd9);
        run_instr(OP_LT, 2'd3, 3'd1, 3'd2, 3'd0, 3'd1, 3'd0, 0, 3'd0, 64'd0, dc, nd, db, eo0, eop, rb_cnt);
        rd_addr = 3'd1; #1;
        checks++; if (rd_data !== 64'd1) $display("FAIL lt_alias got %h exp 1", rd_data); else passes++;
    endtask

    task automatic test_op_none();
        load_reg(3'd6, 64'h1111_2222_3333_4444);
        run_instr(OP_NONE, 2'd1, 3'd1, 3'd2, 3'd3, 3'd6, 3'd1, 0, 3'd0, 64'd0, dc, nd, db, eo0, eop, rb_cnt);
        rd_addr = 3'd6; #1;
        checks++; if (rd_data !== 64'h1111_2222_0000_4444 || db !== 1'b0) $display("FAIL op0 got %h/%b exp 1111222200004444/0", rd_data, db); else passes++;
        checks++; if (dc !== 3) $display("FAIL op0_latency got %0d exp 3", dc); else passes++;
        load_reg(3'd6, 64'hFFFF_FFFF_FFFF_FFFF);
        run_instr(4'd9, 2'd2, 3'd1, 3'd2, 3'd3, 3'd6, 3'd1, 0, 3'd0, 64'd0, dc, nd, db, eo0, eop, rb_cnt);
        rd_addr = 3'd6; #1;
        checks++; if (rd_data !== 64'h0000_0000_FFFF_FFFF || db !== 1'b0) $display("FAIL op9 got %h/%b exp 00000000ffffffff/0", rd_data, db); else passes++;
    endtask

    task automatic test_host_races();
        // host write to r4 in WB cycle loses to WB
        load_reg(3'd1, 64'h55);
        load_reg(3'd2, 64'h55);
        load_reg(3'd4, 64'd0);
        run_instr(OP_CMP, 2'd1, 3'd1, 3'd2, 3'd0, 3'd4, 3'd0, 3, 3'd4, 64'h1234, dc, nd, db, eo0, eop, rb_cnt);
        rd_addr = 3'd4; #1;
        checks++; if (rd_data !== 64'h0001) $display("FAIL wb_wins got %h exp 1", rd_data); else passes++;
        // host write during EXEC survives outside the byte-0 lane
        load_reg(3'd2, 64'h56);
        load_reg(3'd4, 64'h77);
        run_instr(OP_CMP, 2'd0, 3'd1, 3'd2, 3'd0, 3'd4, 3'd0, 2, 3'd4, 64'hFFFF_0000, dc, nd, db, eo0, eop, rb_cnt);
        rd_addr = 3'd4; #1;
        checks++; if (rd_data !== 64'hFFFF_0000) $display("FAIL exec_host_kept got %h exp ffff0000", rd_data); else passes++;
        // host write to a source at the FETCH edge is not seen by the operands
        load_reg(3'd1, 64'hFF);
        load_reg(3'd2, 64'hFF);
        run_instr(OP_CMP, 2'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd0, 1, 3'd1, 64'h0, dc, nd, db, eo0, eop, rb_cnt);
        checks++; if (db !== 1'b1 || eo0 !== 64'hFF) $display("FAIL fetch_preedge got %b/%h exp 1/ff", db, eo0); else passes++;
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int n = 0, ndn = 0, bad = 0;
        load_reg(3'd7, 64'd0);
        i_op = OP_CMP; i_size = 2'd0; i_ra = 3'd2; i_rb = 3'd2; i_rc = 3'd0; i_rd = 3'd7;
        i_s0 = 3'd0; i_s1 = 3'd0; i_s2 = 3'd0; i_sres = 3'd0;
        i_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (i_valid && i_ready && n < 3) begin acc[n] = c; n++; end
            if (busy && i_ready) bad++;
            if (done) ndn++;
            @(posedge sys_clk); #1;
            if (n == 3) i_valid = 1'b0;
        end
        checks++; if (n !== 3) $display("FAIL b2b_accepts got %0d exp 3", n); else passes++;
        checks++; if (n == 3 && (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4))
            $display("FAIL b2b_spacing got %0d,%0d exp 4,4", acc[1] - acc[0], acc[2] - acc[1]); else passes++;
        checks++; if (ndn !== 3) $display("FAIL b2b_done got %0d exp 3", ndn); else passes++;
        checks++; if (bad !== 0) $display("FAIL b2b_ready_busy got %0d exp 0", bad); else passes++;
        rd_addr = 3'd7; #1;
        checks++; if (rd_data !== 64'd1) $display("FAIL b2b_r7 got %h exp 1", rd_data); else passes++;
    endtask

    task automatic test_reset_mid();
        int nd2 = 0;
        load_reg(3'd1, 64'hFF);
        load_reg(3'd2, 64'hFF);
        load_reg(3'd4, 64'h1234_5678);
        i_op = OP_CMP; i_size = 2'd0; i_ra = 3'd1; i_rb = 3'd2; i_rc = 3'd0; i_rd = 3'd4;
        i_s0 = 3'd0; i_s1 = 3'd0; i_s2 = 3'd0; i_sres = 3'd0;
        i_valid = 1'b1;
        @(posedge sys_clk); #1;   // FETCH
        i_valid = 1'b0;
        @(posedge sys_clk); #1;   // EXEC
        sys_rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || i_ready !== 1'b1) $display("FAIL rst_mid_state got busy=%b rdy=%b exp 0/1", busy, i_ready); else passes++;
        checks++; if (alu_o0 !== 64'd0 || alu_op !== 4'd0) $display("FAIL rst_mid_alu got %h/%h exp 0/0", alu_o0, alu_op); else passes++;
        for (int c = 0; c < 3; c++) begin
            if (done) nd2++;
            @(posedge sys_clk); #1;
        end
        sys_rst_n = 1'b1;
        checks++; if (nd2 !== 0) $display("FAIL rst_mid_done got %0d exp 0", nd2); else passes++;
        rd_addr = 3'd4; #1;
        checks++; if (rd_data !== 64'd0) $display("FAIL rst_mid_reg got %h exp 0", rd_data); else passes++;
        // first accept right after release; r1=r2=0 after reset so CMP is true
        run_instr(OP_CMP, 2'd0, 3'd1, 3'd2, 3'd0, 3'd4, 3'd1, 0, 3'd0, 64'd0, dc, nd, db, eo0, eop, rb_cnt);
        rd_addr = 3'd4; #1;
        checks++; if (dc !== 3 || db !== 1'b1 || rd_data !== 64'h100) $display("FAIL rst_after got %0d/%b/%h exp 3/1/100", dc, db, rd_data); else passes++;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        i_valid = 1'b0; i_op = '0; i_size = '0;
        i_ra = '0; i_rb = '0; i_rc = '0; i_rd = '0;
        i_s0 = '0; i_s1 = '0; i_s2 = '0; i_sres = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        #3;
        test_reset();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        test_cmp();
        test_lt();
        test_op_none();
        test_host_races();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
